// File: rtl/kbd_rx_pkg.sv
// Shared definitions for the keyboard serial receiver and its byte FIFO.
package kbd_rx_pkg;

  localparam int DEF_CLKS_PER_BIT = 16;
  localparam int DEF_DEPTH        = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// 8-bit first-word fall-through FIFO; level alone tells full from empty.
module sync_fifo
  import kbd_rx_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic       clk,
  input  logic       rstT,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       full,
  output logic       empty,
  output logic [4:0] level
);

  localparam int          PW       = $clog2(DEPTH);
  localparam logic [4:0]  LVL_FULL = 5'(DEPTH);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [4:0]    level_q, level_d;
  logic [7:0]    mem_q [DEPTH];
  logic          do_push, do_pop;

  assign full    = (level_q == LVL_FULL);
  assign empty   = (level_q == 5'd0);
  assign level   = level_q;
  // A pop frees the slot the simultaneous push needs, so full only blocks a lone push.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? 8'h00 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    unique case ({do_push, do_pop})
      2'b10:   level_d = level_q + 5'd1;
      2'b01:   level_d = level_q - 5'd1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge rstT) begin
    if (rstT) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/kbd_rx_fifo.sv
// 8N1 keyboard receiver feeding a small FIFO that the CPU drains via INP.
module kbd_rx_fifo
  import kbd_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int DEPTH        = DEF_DEPTH
) (
  input  logic       clk,
  input  logic       rstT,
  input  logic       rxd,
  input  logic       inp_take,
  input  logic       clr_err,
  output logic [7:0] keyboard,
  output logic       en_inp,
  output logic [4:0] level,
  output logic       overrun,
  output logic       frame_err
);

  localparam int          CW      = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  rx_state_e     state_q, state_d;
  logic [1:0]    sync_q, sync_d;
  logic          prev_q, prev_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          overrun_q, overrun_d;
  logic          frame_err_q, frame_err_d;
  logic          rxs, fall, baud_zero, push, fe_set, ov_set;
  logic          fifo_full, fifo_empty;

  assign rxs       = sync_q[1];
  assign fall      = prev_q && !rxs;
  assign baud_zero = (baud_q == '0);

  // State register
  always_ff @(posedge clk or posedge rstT) begin
    if (rstT) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (fall) state_d = ST_START;
      ST_START: if (baud_zero) state_d = rxs ? ST_IDLE : ST_DATA;
      ST_DATA:  if (baud_zero && bit_q == 3'd7) state_d = ST_STOP;
      ST_STOP:  if (baud_zero) state_d = ST_IDLE;
    endcase
  end

  // Output / datapath logic
  always_comb begin
    sync_d  = {sync_q[0], rxd};
    prev_d  = rxs;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    push    = 1'b0;
    fe_set  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (fall) begin
          baud_d = HALF_M1;
          bit_d  = 3'd0;
        end
      end
      ST_START: baud_d = baud_zero ? FULL_M1 : baud_q - CW'(1);
      ST_DATA: begin
        if (baud_zero) begin
          shift_d[bit_q] = rxs;
          bit_d          = bit_q + 3'd1;
          baud_d         = FULL_M1;
        end else begin
          baud_d = baud_q - CW'(1);
        end
      end
      ST_STOP: begin
        if (baud_zero) begin
          push   = rxs;
          fe_set = !rxs;
        end else begin
          baud_d = baud_q - CW'(1);
        end
      end
    endcase
    // Full implies non-empty, so a coincident take always makes room.
    ov_set      = push && fifo_full && !inp_take;
    overrun_d   = (overrun_q && !clr_err) || ov_set;
    frame_err_d = (frame_err_q && !clr_err) || fe_set;
  end

  always_ff @(posedge clk or posedge rstT) begin
    if (rstT) begin
      sync_q      <= 2'b11;
      prev_q      <= 1'b1;
      baud_q      <= '0;
      bit_q       <= '0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      prev_q      <= prev_d;
      baud_q      <= baud_d;
      bit_q       <= bit_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  sync_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rstT  (rstT),
    .push  (push),
    .pop   (inp_take),
    .wdata (shift_q),
    .rdata (keyboard),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  assign en_inp    = !fifo_empty;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;

endmodule
